data_cache_ctrl: RTL and testbench

Controller for the direct-mapped, write-allocate, write-back data cache. It sits between the CPU load/store port, the data cache SRAM and the DRAM block interface. It holds the tag/valid/dirty store and sequences every hit, write-back and refill. The data SRAM is driven exclusively by this block.

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_tag_store.sv | 59 +++++
 rtl/data_cache_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared geometry, line type and FSM state encoding for the data cache controller.
// Latency: none (types and constants only).
// Backpressure: not applicable.

`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif
`ifndef DCACHE_INDEX
`define DCACHE_INDEX 4
`endif
`ifndef DCACHE_SIZE
`define DCACHE_SIZE (1 << `DCACHE_INDEX)
`endif

package dcache_pkg;
  localparam int DC_ADDR_W      = 32;
  localparam int DC_WORD_W      = `DRAM_WORD_SIZE;
  localparam int DC_BLOCK_WORDS = `DRAM_BLOCK_SIZE;
  localparam int DC_INDEX_W     = `DCACHE_INDEX;
  localparam int OFFSET_W       = $clog2(DC_BLOCK_WORDS);
  localparam int TAG_W          = DC_ADDR_W - DC_INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } dcache_state_t;

  // One cache line: BLOCK_WORDS words, word 0 in the low bits.
  typedef logic [DC_BLOCK_WORDS-1:0][DC_WORD_W-1:0] line_t;
endpackage

// File: rtl/dcache_tag_store.sv
// Tag/valid/dirty store, one entry per line, addressed by the current CPU index.
// Latency: combinational read, write takes effect at the next rising edge.
// Backpressure: none; a fill and a dirty-mark are accepted every cycle.

module dcache_tag_store #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  input  logic               fill_vld,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic               mark_dirty_vld
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]            valid_q, valid_d;
  logic [LINES-1:0]            dirty_q, dirty_d;
  logic [LINES-1:0][TAG_W-1:0] tag_q, tag_d;

  assign rd_tag   = tag_q[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];

  // A refill installs a clean line; a store hit marks the line dirty.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (fill_vld) begin
      tag_d[index]   = fill_tag;
      valid_d[index] = 1'b1;
      dirty_d[index] = 1'b0;
    end
    if (mark_dirty_vld) begin
      dirty_d[index] = 1'b1;
    end
  end

  // Valid/dirty must clear on reset so every line starts as a miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tags are meaningless while invalid, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end
endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-allocate write-back data cache controller; DCACHE_STATS_EN builds hit/miss counters.
// Latency: hit 1 cycle after acceptance; miss adds ALLOCATE (and WRITEBACK if dirty) DRAM occupancy plus a retry compare.
// Backpressure: CPU is held via cpu_ready; DRAM requests are level-held until mem_ready, one outstanding at a time.

module data_cache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W      = DC_ADDR_W,
  parameter int WORD_W      = DC_WORD_W,
  parameter int BLOCK_WORDS = DC_BLOCK_WORDS,
  parameter int INDEX_W     = DC_INDEX_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cpu_req,
  input  logic                               cpu_rw,
  input  logic [ADDR_W-1:0]                  cpu_addr,
  input  logic [WORD_W-1:0]                  cpu_wdata,
  output logic                               cpu_ready,
  output logic [WORD_W-1:0]                  cpu_rdata,
  output logic                               sram_we,
  output logic [INDEX_W-1:0]                 sram_index,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0] sram_wdata,
  input  logic [BLOCK_WORDS-1:0][WORD_W-1:0] sram_rdata,
  output logic                               mem_req,
  output logic                               mem_rw,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0] mem_wdata,
  input  logic                               mem_ready,
  input  logic [BLOCK_WORDS-1:0][WORD_W-1:0] mem_rdata,
  output logic [31:0]                        hit_count,
  output logic [31:0]                        miss_count
);
  // BLOCK_WORDS is a power of two, at least 2.
  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int CTAG_W = ADDR_W - INDEX_W - OFF_W;

  logic [CTAG_W-1:0]  cpu_tag;
  logic [INDEX_W-1:0] cpu_index;
  logic [OFF_W-1:0]   cpu_offset;
  logic [CTAG_W-1:0]  tag_rd;
  logic               tag_valid, tag_dirty, hit;
  logic               fill_vld, mark_dirty_vld;
  logic [ADDR_W-1:0]  fetch_addr, victim_addr;

  dcache_state_t                       state_q, state_d;
  logic                                mem_req_q, mem_req_d;
  logic                                mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]                   mem_addr_q, mem_addr_d;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0]  mem_wdata_q, mem_wdata_d;

  assign cpu_tag     = cpu_addr[ADDR_W-1 -: CTAG_W];
  assign cpu_index   = cpu_addr[OFF_W +: INDEX_W];
  assign cpu_offset  = cpu_addr[OFF_W-1:0];
  assign sram_index  = cpu_index;
  assign fetch_addr  = {cpu_tag, cpu_index, {OFF_W{1'b0}}};
  assign victim_addr = {tag_rd, cpu_index, {OFF_W{1'b0}}};
  assign hit         = tag_valid && (tag_rd == cpu_tag);

  assign mem_req   = mem_req_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  dcache_tag_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (CTAG_W)
  ) u_tag_store (
    .clk            (clk),
    .rst            (rst),
    .index          (cpu_index),
    .rd_tag         (tag_rd),
    .rd_valid       (tag_valid),
    .rd_dirty       (tag_dirty),
    .fill_vld       (fill_vld),
    .fill_tag       (cpu_tag),
    .mark_dirty_vld (mark_dirty_vld)
  );

  // Next-state and DRAM request decode; CPU/SRAM strobes stay combinational
  // because the hit decision depends on this cycle's tag and SRAM read.
  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_rw_d       = mem_rw_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_ready      = 1'b0;
    cpu_rdata      = '0;
    sram_we        = 1'b0;
    sram_wdata     = '0;
    fill_vld       = 1'b0;
    mark_dirty_vld = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = sram_rdata[cpu_offset];
          state_d   = IDLE;
          if (cpu_rw) begin
            sram_we                = 1'b1;
            sram_wdata             = sram_rdata;
            sram_wdata[cpu_offset] = cpu_wdata;
            mark_dirty_vld         = 1'b1;
          end
        end else if (tag_valid && tag_dirty) begin
          // Victim line is captured here so mem_wdata cannot move mid-transfer.
          state_d     = WRITEBACK;
          mem_req_d   = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = victim_addr;
          mem_wdata_d = sram_rdata;
        end else begin
          state_d    = ALLOCATE;
          mem_req_d  = 1'b1;
          mem_rw_d   = 1'b0;
          mem_addr_d = fetch_addr;
        end
      end
      WRITEBACK: begin
        // Request stays up and turns straight into the refill fetch.
        if (mem_ready) begin
          state_d    = ALLOCATE;
          mem_rw_d   = 1'b0;
          mem_addr_d = fetch_addr;
        end
      end
      ALLOCATE: begin
        if (mem_ready) begin
          sram_we    = 1'b1;
          sram_wdata = mem_rdata;
          fill_vld   = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered DRAM request; reset drops mem_req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        retry_q, retry_d;

  // Count first-pass lookups only; the compare that follows a refill is a retry.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    retry_d      = retry_q;
    if (state_q == COMPARE && !retry_q) begin
      if (hit) hit_count_d  = hit_count_q + 32'd1;
      else     miss_count_d = miss_count_q + 32'd1;
    end
    if (state_q == COMPARE && hit)        retry_d = 1'b0;
    if (state_q == ALLOCATE && mem_ready) retry_d = 1'b1;
  end

  // Statistics registers, free-running modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      retry_q      <= 1'b0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      retry_q      <= retry_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: random loads/stores against a flat-memory cache model.
// Latency: DRAM responder replies after a random 1-4 cycle delay, or stalls on demand.
// Backpressure: the CPU driver holds each request until cpu_ready.

module tb_data_cache_ctrl;
  import dcache_pkg::*;

  localparam int AW    = DC_ADDR_W;
  localparam int WW    = DC_WORD_W;
  localparam int BW    = DC_BLOCK_WORDS;
  localparam int IW    = DC_INDEX_W;
  localparam int OW    = OFFSET_W;
  localparam int LINES = 1 << IW;

  localparam int K_WB    = 0;
  localparam int K_FETCH = 1;
  localparam int K_READY = 2;

  typedef struct {
    int          kind;
    logic [AW-1:0] addr;
    line_t       line;
    logic [WW-1:0] data;
    bit          hit;
    bit          store;
    int          off;
  } ev_t;

  logic          clk, rst;
  logic          cpu_req, cpu_rw, cpu_ready;
  logic [AW-1:0] cpu_addr;
  logic [WW-1:0] cpu_wdata, cpu_rdata;
  logic          sram_we;
  logic [IW-1:0] sram_index;
  line_t         sram_wdata, sram_rdata;
  logic          mem_req, mem_rw, mem_ready;
  logic [AW-1:0] mem_addr;
  line_t         mem_wdata, mem_rdata;
  logic [31:0]   hit_count, miss_count;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int issue_cyc = 0;
  ev_t exp_q[$];

  // Reference model state: what each cache slot holds and what DRAM holds.
  line_t        ref_line [LINES];
  int unsigned  ref_tag  [LINES];
  bit           ref_valid[LINES];
  bit           ref_dirty[LINES];
  line_t        ref_dram [int unsigned];
  int           m_hits = 0;
  int           m_misses = 0;

  // DRAM environment state.
  line_t        dram_env [int unsigned];
  bit           dram_stall = 0;
  int           spur_want = 0;
  int           spur_done = 0;

  // Bench-side data SRAM: combinational read, write at the rising edge.
  line_t        sram_mem [LINES];

  data_cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_rw     (cpu_rw),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .sram_we    (sram_we),
    .sram_index (sram_index),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .mem_req    (mem_req),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  assign sram_rdata = sram_mem[sram_index];
  always @(posedge clk) begin
    if (sram_we) sram_mem[sram_index] <= sram_wdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Power-on DRAM contents; word 0x40 is 0xA5 so the first refill is recognisable.
  function automatic line_t init_line(input int unsigned la);
    line_t l;
    for (int w = 0; w < BW; w++) begin
      int unsigned wa;
      wa = la + w;
      l[w] = (wa == 32'h40) ? WW'(32'hA5) : WW'((wa * 32'h9E3779B1) ^ 32'h5A5A0000);
    end
    return l;
  endfunction

  function automatic line_t ref_dram_get(input int unsigned la);
    if (ref_dram.exists(la)) return ref_dram[la];
    return init_line(la);
  endfunction

  // Reference: direct-mapped write-back cache over a flat word memory.
  task automatic model_access(input logic [AW-1:0] a, input bit rw, input logic [WW-1:0] wd);
    int unsigned idx, tg, off, la, va;
    bit hit;
    ev_t e;
    idx = (a >> OW) % LINES;
    tg  = a >> (OW + IW);
    off = a % BW;
    la  = a - off;
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    if (!hit) begin
      m_misses++;
      if (ref_valid[idx] && ref_dirty[idx]) begin
        va = (ref_tag[idx] << (OW + IW)) + (idx << OW);
        e = '{kind: K_WB, addr: AW'(va), line: ref_line[idx], data: '0, hit: 0, store: 0, off: 0};
        exp_q.push_back(e);
        ref_dram[va] = ref_line[idx];
      end
      e = '{kind: K_FETCH, addr: AW'(la), line: '0, data: '0, hit: 0, store: 0, off: 0};
      exp_q.push_back(e);
      ref_line[idx]  = ref_dram_get(la);
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
      ref_dirty[idx] = 1'b0;
    end else begin
      m_hits++;
    end
    if (rw) begin
      ref_line[idx][off] = wd;
      ref_dirty[idx]     = 1'b1;
    end
    e = '{kind: K_READY, addr: a, line: '0, data: ref_line[idx][off], hit: hit, store: rw, off: int'(off)};
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < LINES; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  // DRAM responder: one transfer at a time, random latency, optional stall.
  initial begin
    bit            busy = 0;
    int            cnt = 0;
    logic [AW-1:0] t_addr = '0;
    bit            t_rw = 0;
    line_t         t_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 0;
        mem_ready = 1'b0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        busy = 0;
      end else if (busy) begin
        if (!dram_stall) begin
          if (cnt == 0) begin
            mem_ready = 1'b1;
            if (t_rw) dram_env[int'(t_addr)] = t_wdata;
            else mem_rdata = dram_env.exists(int'(t_addr)) ? dram_env[int'(t_addr)] : init_line(t_addr);
          end else begin
            cnt--;
          end
        end
      end else if (mem_req) begin
        busy = 1;
        cnt = $urandom_range(0, 3);
        t_addr = mem_addr;
        t_rw = mem_rw;
        t_wdata = mem_wdata;
      end else if (spur_done != spur_want) begin
        spur_done++;
        mem_ready = 1'b1;
        mem_rdata = {BW{WW'($urandom)}};
      end
    end
  end

  task automatic pop_ev(output ev_t e, output bit ok);
    e = '{kind: -1, addr: '0, line: '0, data: '0, hit: 0, store: 0, off: 0};
    if (exp_q.size() == 0) begin
      ok = 0;
      compared++;
      mismatched++;
      $display("FAIL scoreboard_empty: DUT event (mem_req=%0b cpu_ready=%0b) with nothing expected", mem_req, cpu_ready);
    end else begin
      ok = 1;
      e = exp_q.pop_front();
    end
  endtask

  // Monitor: observes DRAM transfers and CPU completions and checks them in order.
  initial begin
    bit            in_txn = 0;
    bit            t_rw = 0;
    logic [AW-1:0] t_addr = '0;
    line_t         t_wdata = '0;
    ev_t           e;
    bit            ok;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_txn = 0;
      end else begin
        if (in_txn) begin
          chk("mem_req_held", mem_req, 1'b1);
          chk("mem_addr_stable", mem_addr, t_addr);
          if (t_rw) chk("mem_wdata_stable", mem_wdata, t_wdata);
        end else if (mem_req) begin
          pop_ev(e, ok);
          if (ok) begin
            chk("mem_kind", mem_rw ? K_WB : K_FETCH, e.kind);
            chk("mem_addr", mem_addr, e.addr);
            if (e.kind == K_WB) chk("wb_line", mem_wdata, e.line);
          end
          in_txn = 1;
          t_rw = mem_rw;
          t_addr = mem_addr;
          t_wdata = mem_wdata;
        end
        if (mem_ready) begin
          if (in_txn) begin
            if (!t_rw) begin
              chk("refill_sram_we", sram_we, 1'b1);
              chk("refill_sram_wdata", sram_wdata, mem_rdata);
            end
            in_txn = 0;
          end else begin
            chk("spurious_sram_we", sram_we, 1'b0);
            chk("spurious_cpu_ready", cpu_ready, 1'b0);
          end
        end
        if (cpu_ready) begin
          pop_ev(e, ok);
          if (ok) begin
            chk("ready_kind", K_READY, e.kind);
            if (e.store) begin
              chk("store_sram_we", sram_we, 1'b1);
              chk("store_sram_word", sram_wdata[e.off], e.data);
            end else begin
              chk("load_rdata", cpu_rdata, e.data);
              chk("load_sram_we", sram_we, 1'b0);
            end
            if (e.hit) chk("hit_latency", cyc - issue_cyc, 1);
          end
        end
      end
    end
  end

  task automatic access(input logic [AW-1:0] a, input bit rw, input logic [WW-1:0] wd);
    @(posedge clk);
    #1;
    model_access(a, rw, wd);
    cpu_addr = a;
    cpu_rw = rw;
    cpu_wdata = wd;
    cpu_req = 1'b1;
    issue_cyc = cyc;
    for (int n = 0; n < 200 && !cpu_ready; n++) @(negedge clk);
    if (!cpu_ready) begin
      compared++;
      mismatched++;
      $display("FAIL access_timeout: addr %0h got no cpu_ready within 200 cycles", a);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic chk_stats();
`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
`else
    chk("hit_count_tied", hit_count, 0);
    chk("miss_count_tied", miss_count, 0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_rw = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    model_reset();
    @(negedge clk);
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_sram_we", sram_we, 1'b0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean miss, then a hit on the same word, then a store hit.
    access(AW'(32'h40), 1'b0, '0);
    access(AW'(32'h40), 1'b0, '0);
    chk_stats();
    access(AW'(32'h41), 1'b1, WW'(32'hDEAD));
    // Conflict miss on index 0 forces the dirty line out first.
    access(AW'(32'h80), 1'b0, '0);

    // Stray mem_ready while idle must be ignored; a following hit proves the state held.
    @(posedge clk);
    #1;
    spur_want++;
    repeat (3) @(posedge clk);
    access(AW'(32'h80), 1'b0, '0);

    // Reset while a refill is stalled in flight.
    @(posedge clk);
    #1;
    model_access(AW'(32'h1C4), 1'b0, '0);
    dram_stall = 1'b1;
    cpu_addr = AW'(32'h1C4);
    cpu_rw = 1'b0;
    cpu_req = 1'b1;
    for (int n = 0; n < 50 && !mem_req; n++) @(negedge clk);
    chk("alloc_mem_req_up", mem_req, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_mem_req", mem_req, 1'b0);
    chk("rst_async_cpu_ready", cpu_ready, 1'b0);
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    dram_stall = 1'b0;
    rst = 1'b0;
    chk_stats();
    // Index 0 held a valid line before reset; it must miss now.
    access(AW'(32'h80), 1'b0, '0);

    // Random mix over 4 tags x 4 indices to exercise hits, clean and dirty misses.
    for (int i = 0; i < 200; i++) begin
      logic [AW-1:0] a;
      a = AW'(($urandom_range(0, 3) << (OW + IW)) + ($urandom_range(0, 3) << OW) + $urandom_range(0, BW - 1));
      access(a, ($urandom_range(0, 9) < 4), WW'($urandom));
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
